// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I datapath: steps FETCH/DECODE/EXEC/MEM/WB.
// Latency: 3 to 5 cycles per instruction with zero wait states, plus one per memory wait cycle.
// Backpressure: FETCH and MEM hold MemReq/IorD/MemWe stable until mem_ready; TRAP is left only by reset.
module multicycle_controller #(
    parameter int unsigned FETCH_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       BrTaken,
    input  logic       mem_ready,
    output logic       MemReq,
    output logic       MemWe,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic [1:0] WBSel,
    output logic       retire,
    output logic       illegal,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t      state_q, state_d;
    logic [31:0] wait_q, wait_d;
    logic        op_legal;

    // Opcode legality check used by DECODE.
    always_comb begin
        case (Opcode)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    end

    // State and consecutive fetch-wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state and per-cycle datapath controls; everything is forced low while reset is held.
    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        MemReq   = 1'b0;
        MemWe    = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 2'b00;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        RegWrite = 1'b0;
        WBSel    = 2'b00;
        retire   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemReq  = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if ((FETCH_WAIT_MAX != 0) && (wait_q == FETCH_WAIT_MAX - 1)) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_DECODE: begin
                // ALUOut captures OldPC+imm for branch/JAL targets.
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
                state_d = op_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (Opcode)
                    OP_R: begin
                        ALUSrcA = 2'b01; ALUSrcB = 2'b00; ALUOp = 2'b10;
                        state_d = S_WB;
                    end
                    OP_I: begin
                        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUOp = 2'b11;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrcA = 2'b01; ALUSrcB = 2'b10;
                        state_d = S_MEM;
                    end
                    OP_BR: begin
                        ALUSrcA = 2'b01; ALUSrcB = 2'b00; ALUOp = 2'b01;
                        PCWrite = BrTaken;
                        PCSrc   = BrTaken ? 2'b01 : 2'b00;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JAL: begin
                        // PC already holds OldPC+4, which is the link value.
                        RegWrite = 1'b1; WBSel = 2'b10;
                        PCWrite = 1'b1; PCSrc = 2'b01;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JALR: begin
                        ALUSrcA = 2'b01; ALUSrcB = 2'b10;
                        RegWrite = 1'b1; WBSel = 2'b10;
                        PCWrite = 1'b1; PCSrc = 2'b10;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_LUI: begin
                        RegWrite = 1'b1; WBSel = 2'b11;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_AUIPC: begin
                        RegWrite = 1'b1; WBSel = 2'b00;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                MemWe  = (Opcode == OP_SW);
                if (mem_ready) begin
                    if (Opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                WBSel    = (Opcode == OP_LW) ? 2'b01 : 2'b00;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
        if (reset) begin
            MemReq   = 1'b0;
            MemWe    = 1'b0;
            IorD     = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            PCSrc    = 2'b00;
            ALUSrcA  = 2'b00;
            ALUSrcB  = 2'b00;
            ALUOp    = 2'b00;
            RegWrite = 1'b0;
            WBSel    = 2'b00;
            retire   = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq;
        logic       mwe;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic [1:0] asrc;
        logic [1:0] bsrc;
        logic [1:0] aop;
        logic       rw;
        logic [1:0] wbs;
        logic       ret;
        logic       ill;
    } exp_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] Opcode = 7'd0;
    logic       BrTaken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       MemReq, MemWe, IorD, IRWrite, PCWrite, RegWrite, retire, illegal;
    logic [1:0] PCSrc, ALUSrcA, ALUSrcB, ALUOp, WBSel;
    logic [2:0] state_o;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    string lbl_q[$];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .BrTaken(BrTaken), .mem_ready(mem_ready),
        .MemReq(MemReq), .MemWe(MemWe), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .WBSel(WBSel), .retire(retire), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Field order: state, MemReq, MemWe, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
    // RegWrite, WBSel, retire, illegal.
    function automatic exp_t e(int st, int mreq, int mwe, int iord, int irw, int pcw, int pcsrc,
                               int asrc, int bsrc, int aop, int rw, int wbs, int ret, int ill);
        exp_t x;
        x.st = 3'(st); x.mreq = 1'(mreq); x.mwe = 1'(mwe); x.iord = 1'(iord);
        x.irw = 1'(irw); x.pcw = 1'(pcw); x.pcsrc = 2'(pcsrc); x.asrc = 2'(asrc);
        x.bsrc = 2'(bsrc); x.aop = 2'(aop); x.rw = 1'(rw); x.wbs = 2'(wbs);
        x.ret = 1'(ret); x.ill = 1'(ill);
        return x;
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
    task automatic cyc(input string lbl, input logic rst, input logic [6:0] op,
                       input logic br, input logic rdy, input exp_t ex);
        @(posedge clk);
        #1;
        reset     = rst;
        Opcode    = op;
        BrTaken   = br;
        mem_ready = rdy;
        exp_q.push_back(ex);
        lbl_q.push_back(lbl);
    endtask

    // Monitor: sample mid-cycle and compare against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  ex;
            exp_t  act;
            string lbl;
            ex  = exp_q.pop_front();
            lbl = lbl_q.pop_front();
            act = {state_o, MemReq, MemWe, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
                   ALUOp, RegWrite, WBSel, retire, illegal};
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL %s: got st=%0d req=%b we=%b iord=%b irw=%b pcw=%b pcsrc=%b a=%b b=%b op=%b rw=%b wbs=%b ret=%b ill=%b ; want st=%0d req=%b we=%b iord=%b irw=%b pcw=%b pcsrc=%b a=%b b=%b op=%b rw=%b wbs=%b ret=%b ill=%b",
                         lbl, act.st, act.mreq, act.mwe, act.iord, act.irw, act.pcw, act.pcsrc,
                         act.asrc, act.bsrc, act.aop, act.rw, act.wbs, act.ret, act.ill,
                         ex.st, ex.mreq, ex.mwe, ex.iord, ex.irw, ex.pcw, ex.pcsrc,
                         ex.asrc, ex.bsrc, ex.aop, ex.rw, ex.wbs, ex.ret, ex.ill);
            end
        end
    end

    exp_t Z, F_RDY, F_WAIT, DEC;

    initial begin
        Z      = e(0, 0,0,0,0,0,0, 0,0,0, 0,0,0,0);
        F_RDY  = e(0, 1,0,0,1,1,0, 0,1,0, 0,0,0,0);
        F_WAIT = e(0, 1,0,0,0,0,0, 0,1,0, 0,0,0,0);
        DEC    = e(1, 0,0,0,0,0,0, 2,2,0, 0,0,0,0);

        // Reset held three cycles with mem_ready high: everything quiet.
        for (int i = 0; i < 3; i++) cyc("reset_hold", 1'b1, OP_R, 1'b0, 1'b1, Z);

        // R-type: 0,1,2,4 then back to FETCH.
        cyc("r_fetch",  1'b0, OP_R, 1'b0, 1'b1, F_RDY);
        cyc("r_decode", 1'b0, OP_R, 1'b0, 1'b1, DEC);
        cyc("r_exec",   1'b0, OP_R, 1'b0, 1'b1, e(2, 0,0,0,0,0,0, 1,0,2, 0,0,0,0));
        cyc("r_wb",     1'b0, OP_R, 1'b0, 1'b1, e(4, 0,0,0,0,0,0, 0,0,0, 1,0,1,0));

        // LW with two memory wait cycles.
        cyc("lw_fetch",  1'b0, OP_LW, 1'b0, 1'b1, F_RDY);
        cyc("lw_decode", 1'b0, OP_LW, 1'b0, 1'b1, DEC);
        cyc("lw_exec",   1'b0, OP_LW, 1'b0, 1'b1, e(2, 0,0,0,0,0,0, 1,2,0, 0,0,0,0));
        cyc("lw_mem_w1", 1'b0, OP_LW, 1'b0, 1'b0, e(3, 1,0,1,0,0,0, 0,0,0, 0,0,0,0));
        cyc("lw_mem_w2", 1'b0, OP_LW, 1'b0, 1'b0, e(3, 1,0,1,0,0,0, 0,0,0, 0,0,0,0));
        cyc("lw_mem_ok", 1'b0, OP_LW, 1'b0, 1'b1, e(3, 1,0,1,0,0,0, 0,0,0, 0,0,0,0));
        cyc("lw_wb",     1'b0, OP_LW, 1'b0, 1'b1, e(4, 0,0,0,0,0,0, 0,0,0, 1,1,1,0));

        // SW with zero wait: retires in MEM.
        cyc("sw_fetch",  1'b0, OP_SW, 1'b0, 1'b1, F_RDY);
        cyc("sw_decode", 1'b0, OP_SW, 1'b0, 1'b1, DEC);
        cyc("sw_exec",   1'b0, OP_SW, 1'b0, 1'b1, e(2, 0,0,0,0,0,0, 1,2,0, 0,0,0,0));
        cyc("sw_mem",    1'b0, OP_SW, 1'b0, 1'b1, e(3, 1,1,1,0,0,0, 0,0,0, 0,0,1,0));

        // Branch not taken, then taken.
        cyc("brn_fetch",  1'b0, OP_BR, 1'b0, 1'b1, F_RDY);
        cyc("brn_decode", 1'b0, OP_BR, 1'b0, 1'b1, DEC);
        cyc("brn_exec",   1'b0, OP_BR, 1'b0, 1'b1, e(2, 0,0,0,0,0,0, 1,0,1, 0,0,1,0));
        cyc("brt_fetch",  1'b0, OP_BR, 1'b1, 1'b1, F_RDY);
        cyc("brt_decode", 1'b0, OP_BR, 1'b1, 1'b1, DEC);
        cyc("brt_exec",   1'b0, OP_BR, 1'b1, 1'b1, e(2, 0,0,0,0,1,1, 1,0,1, 0,0,1,0));

        // JAL, JALR, LUI, AUIPC: all complete in EXEC.
        cyc("jal_fetch",    1'b0, OP_JAL, 1'b0, 1'b1, F_RDY);
        cyc("jal_decode",   1'b0, OP_JAL, 1'b0, 1'b1, DEC);
        cyc("jal_exec",     1'b0, OP_JAL, 1'b0, 1'b1, e(2, 0,0,0,0,1,1, 0,0,0, 1,2,1,0));
        cyc("jalr_fetch",   1'b0, OP_JALR, 1'b0, 1'b1, F_RDY);
        cyc("jalr_decode",  1'b0, OP_JALR, 1'b0, 1'b1, DEC);
        cyc("jalr_exec",    1'b0, OP_JALR, 1'b0, 1'b1, e(2, 0,0,0,0,1,2, 1,2,0, 1,2,1,0));
        cyc("lui_fetch",    1'b0, OP_LUI, 1'b0, 1'b1, F_RDY);
        cyc("lui_decode",   1'b0, OP_LUI, 1'b0, 1'b1, DEC);
        cyc("lui_exec",     1'b0, OP_LUI, 1'b0, 1'b1, e(2, 0,0,0,0,0,0, 0,0,0, 1,3,1,0));
        cyc("auipc_fetch",  1'b0, OP_AUIPC, 1'b0, 1'b1, F_RDY);
        cyc("auipc_decode", 1'b0, OP_AUIPC, 1'b0, 1'b1, DEC);
        cyc("auipc_exec",   1'b0, OP_AUIPC, 1'b0, 1'b1, e(2, 0,0,0,0,0,0, 0,0,0, 1,0,1,0));

        // I-type through WB.
        cyc("i_fetch",  1'b0, OP_I, 1'b0, 1'b1, F_RDY);
        cyc("i_decode", 1'b0, OP_I, 1'b0, 1'b1, DEC);
        cyc("i_exec",   1'b0, OP_I, 1'b0, 1'b1, e(2, 0,0,0,0,0,0, 1,2,3, 0,0,0,0));
        cyc("i_wb",     1'b0, OP_I, 1'b0, 1'b1, e(4, 0,0,0,0,0,0, 0,0,0, 1,0,1,0));

        // Fetch wait, then reset mid-wait drops MemReq immediately.
        cyc("fw_wait1",   1'b0, OP_R, 1'b0, 1'b0, F_WAIT);
        cyc("fw_wait2",   1'b0, OP_R, 1'b0, 1'b0, F_WAIT);
        cyc("fw_rst",     1'b1, OP_R, 1'b0, 1'b0, Z);
        cyc("fw_rst2",    1'b1, OP_R, 1'b0, 1'b1, Z);
        cyc("fw_release", 1'b0, OP_R, 1'b0, 1'b0, F_WAIT);

        // Illegal opcode: TRAP holds with illegal=1 and no retire until reset.
        cyc("bad_fetch",  1'b0, OP_BAD, 1'b0, 1'b1, F_RDY);
        cyc("bad_decode", 1'b0, OP_BAD, 1'b0, 1'b1, DEC);
        for (int i = 0; i < 3; i++) cyc("trap_hold", 1'b0, OP_R, 1'b1, 1'b1, e(5, 0,0,0,0,0,0, 0,0,0, 0,0,0,1));
        cyc("trap_rst",     1'b1, OP_R, 1'b0, 1'b1, Z);
        cyc("trap_release", 1'b0, OP_R, 1'b0, 1'b1, F_RDY);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
